regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 44 ++++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the clear FSM state
// encoding and the default geometry.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: address decode over the flattened array,
// same-cycle write forwarding and entry-0 masking.
module regfile_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                 i_rd_addr,
  input  logic [(DATA_W<<ADDR_W)-1:0]       i_mem_flat,
  input  logic                              i_we0_ok,
  input  logic [ADDR_W-1:0]                 i_wa0,
  input  logic [DATA_W-1:0]                 i_wd0,
  input  logic                              i_we1_ok,
  input  logic [ADDR_W-1:0]                 i_wa1,
  input  logic [DATA_W-1:0]                 i_wd1,
  output logic [DATA_W-1:0]                 o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] w_mem_word;
  logic              w_hit0;
  logic              w_hit1;

  always_comb begin
    w_mem_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_rd_addr == ADDR_W'(i)) w_mem_word = i_mem_flat[i*DATA_W +: DATA_W];
    end
  end

  // The *_ok enables already exclude writes dropped while busy or aimed at entry 0.
  assign w_hit0 = (BYPASS != 0) && i_we0_ok && (i_wa0 == i_rd_addr);
  assign w_hit1 = (BYPASS != 0) && i_we1_ok && (i_wa1 == i_rd_addr);

  always_comb begin
    o_rd_data = w_mem_word;
    if (w_hit1)      o_rd_data = i_wd1;
    else if (w_hit0) o_rd_data = i_wd0;
    if ((ZERO_REG != 0) && (i_rd_addr == '0)) o_rd_data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with a background clear sequencer that
// zeroes one entry per cycle and rejects writes while it runs.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NRD*ADDR_W-1:0]    RD_ADDR,
  output logic [NRD*DATA_W-1:0]    RD_DATA,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic                     CLR_REQ,
  output logic                     BUSY,
  output logic                     CLR_DONE,
  output logic                     WR_ERR
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] w_mem_flat;

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;

  logic w_busy;
  logic w_clr_done;
  logic w_we0_ok;
  logic w_we1_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // A request seen while clearing is ignored; the pointer wrap always ends the pass.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_busy        = 1'b0;
    w_clr_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CLR_REQ) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        w_busy        = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST_PTR) begin
          w_clr_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_we0_ok = WE0 && !w_busy && !((ZERO_REG != 0) && (WA0 == '0));
  assign w_we1_ok = WE1 && !w_busy && !((ZERO_REG != 0) && (WA1 == '0));

  assign BUSY     = w_busy;
  assign CLR_DONE = w_clr_done;
  assign WR_ERR   = w_busy && (WE0 || WE1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      if (w_we0_ok) r_mem[WA0] <= WD0;
      if (w_we1_ok) r_mem[WA1] <= WD1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_flat
      assign w_mem_flat[g*DATA_W +: DATA_W] = r_mem[g];
    end

    for (g = 0; g < NRD; g++) begin : g_rd
      regfile_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_rdport (
        .i_rd_addr  (RD_ADDR[g*ADDR_W +: ADDR_W]),
        .i_mem_flat (w_mem_flat),
        .i_we0_ok   (w_we0_ok),
        .i_wa0      (WA0),
        .i_wd0      (WD0),
        .i_we1_ok   (w_we1_ok),
        .i_wa1      (WA1),
        .i_wd1      (WD1),
        .o_rd_data  (RD_DATA[g*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: write/read, collision, zero register,
// clear sequencing, writes during clear and reset mid-clear.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int DEPTH  = 32;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NRD*ADDR_W-1:0] RD_ADDR;
  logic [NRD*DATA_W-1:0] RD_DATA;
  logic                  WE0, WE1, CLR_REQ;
  logic [ADDR_W-1:0]     WA0, WA1;
  logic [DATA_W-1:0]     WD0, WD1;
  logic                  BUSY, CLR_DONE, WR_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .WE0(WE0), .WA0(WA0), .WD0(WD0),
    .WE1(WE1), .WA1(WA1), .WD1(WD1),
    .CLR_REQ(CLR_REQ), .BUSY(BUSY), .CLR_DONE(CLR_DONE), .WR_ERR(WR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [ADDR_W-1:0] addr);
    RD_ADDR[port*ADDR_W +: ADDR_W] = addr;
  endtask

  function automatic logic [31:0] rd(input int port);
    return RD_DATA[port*DATA_W +: DATA_W];
  endfunction

  int busy_cnt, done_cnt, done_at, nz_cnt;

  initial begin
    RESET = 1'b1; RD_ADDR = '0; CLR_REQ = 1'b0;
    WE0 = 1'b0; WA0 = '0; WD0 = '0;
    WE1 = 1'b0; WA1 = '0; WD1 = '0;
    step(); step();
    set_rd(0, 5'd3); #1;
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_done", 32'(CLR_DONE), 32'd0);
    check_val("rst_err", 32'(WR_ERR), 32'd0);
    check_val("rst_rd3", rd(0), 32'd0);

    // first write lands on the first edge after reset release
    RESET = 1'b0;
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF;
    set_rd(0, 5'd5); set_rd(1, 5'd6); #1;
    check_val("byp_wr5", rd(0), 32'hDEADBEEF);
    check_val("nobyp_rd6", rd(1), 32'd0);
    step();
    WE0 = 1'b0; #1;
    check_val("rd5", rd(0), 32'hDEADBEEF);

    // collision: port 1 wins, bypassed same cycle
    WE0 = 1'b1; WA0 = 5'd7; WD0 = 32'h1;
    WE1 = 1'b1; WA1 = 5'd7; WD1 = 32'h2;
    set_rd(1, 5'd7); #1;
    check_val("coll_byp", rd(1), 32'h2);
    check_val("coll_err", 32'(WR_ERR), 32'd0);
    step();
    WE0 = 1'b0; WE1 = 1'b0; #1;
    check_val("coll_rd7", rd(1), 32'h2);

    // zero register
    WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'hFFFFFFFF;
    set_rd(0, 5'd0); #1;
    check_val("zero_byp", rd(0), 32'd0);
    step();
    WE0 = 1'b0; #1;
    check_val("zero_rd", rd(0), 32'd0);

    // preload 1..31 with index (alternate write ports)
    for (int i = 1; i < DEPTH; i++) begin
      if (i % 2 == 0) begin WE0 = 1'b1; WA0 = ADDR_W'(i); WD0 = 32'(i); WE1 = 1'b0; end
      else            begin WE1 = 1'b1; WA1 = ADDR_W'(i); WD1 = 32'(i); WE0 = 1'b0; end
      step();
    end
    WE0 = 1'b0; WE1 = 1'b0;
    set_rd(0, 5'd5); set_rd(1, 5'd31); #1;
    check_val("pre_rd5", rd(0), 32'd5);
    check_val("pre_rd31", rd(1), 32'd31);

    // clear with a write at busy cycle 3 and a repeated request at busy cycle 5
    CLR_REQ = 1'b1; #1;
    check_val("req_busy0", 32'(BUSY), 32'd0);
    step();
    CLR_REQ = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int it = 0; it < 45; it++) begin
      if (BUSY) begin
        busy_cnt++;
        if (CLR_DONE) begin done_cnt++; done_at = busy_cnt; end
        if (busy_cnt == 3) begin
          WE1 = 1'b1; WA1 = 5'd20; WD1 = 32'hAAAA5555;
          set_rd(0, 5'd20); #1;
          check_val("clr_err_pulse", 32'(WR_ERR), 32'd1);
          check_val("clr_no_byp", rd(0), 32'd20);
        end
        if (busy_cnt == 4) begin
          WE1 = 1'b0; #1;
          check_val("clr_err_low", 32'(WR_ERR), 32'd0);
        end
        if (busy_cnt == 5) CLR_REQ = 1'b1;
        if (busy_cnt == 6) CLR_REQ = 1'b0;
        if (busy_cnt == 16) begin
          set_rd(0, 5'd3); set_rd(1, 5'd31); #1;
          check_val("mid_rd3", rd(0), 32'd0);
          check_val("mid_rd31", rd(1), 32'd31);
        end
      end else if (busy_cnt > 0) begin
        break;
      end
      step();
    end
    check_val("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    check_val("clr_done_count", 32'(done_cnt), 32'd1);
    check_val("clr_done_cycle", 32'(done_at), 32'd32);
    check_val("clr_idle_busy", 32'(BUSY), 32'd0);
    nz_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, ADDR_W'(i)); #1;
      if (rd(0) != 32'd0) nz_cnt++;
    end
    check_val("clr_all_zero", 32'(nz_cnt), 32'd0);

    // reset mid-clear
    WE0 = 1'b1; WA0 = 5'd9;  WD0 = 32'h55;
    WE1 = 1'b1; WA1 = 5'd25; WD1 = 32'h77;
    step();
    WE0 = 1'b0; WE1 = 1'b0;
    set_rd(0, 5'd9); set_rd(1, 5'd25); #1;
    check_val("pre_rd9", rd(0), 32'h55);
    CLR_REQ = 1'b1;
    step();
    CLR_REQ = 1'b0;
    busy_cnt = 1;
    for (int it = 0; it < 20 && busy_cnt < 10; it++) begin
      step();
      if (BUSY) busy_cnt++;
    end
    check_val("rst_mid_cycle", 32'(busy_cnt), 32'd10);
    #1 RESET = 1'b1; #1;
    check_val("rst_mid_busy", 32'(BUSY), 32'd0);
    check_val("rst_mid_done", 32'(CLR_DONE), 32'd0);
    check_val("rst_mid_rd9", rd(0), 32'd0);
    check_val("rst_mid_rd25", rd(1), 32'd0);
    step();
    RESET = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int it = 0; it < 40; it++) begin
      if (CLR_DONE) done_cnt++;
      if (BUSY) busy_cnt++;
      step();
    end
    check_val("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check_val("rst_mid_no_busy", 32'(busy_cnt), 32'd0);
    nz_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(1, ADDR_W'(i)); #1;
      if (rd(1) != 32'd0) nz_cnt++;
    end
    check_val("rst_all_zero", 32'(nz_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
